// File: rtl/mac_pkg.sv
// Shared definitions for the GMII receive parser.
// States, framing bytes, CRC-32 constants, helpers.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DEST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [47:0] BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;

  // Reflected CRC-32 update, bits taken LSB first.
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // The residue constant is in MSB-first form; the
  // register is reflected, so compare bit-reversed.
  function automatic logic [31:0] bitrev32(
    input logic [31:0] x
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Registered CRC-32, one byte per clock.
// init has priority over en.
module crc32_d8
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] state
);

  // Running CRC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= CRC_INIT;
    else if (init) state <= CRC_INIT;
    else if (en)   state <= crc_byte(state, data);
  end

endmodule

// File: rtl/mac_rx_parser.sv
// GMII receive parser: preamble/SFD, header capture,
// address filter, FCS strip, CRC/length check, stats.
module mac_rx_parser
  import mac_pkg::*;
#(
  parameter int MAX_FRAME    = 1518,
  parameter int MIN_FRAME    = 64,
  parameter int CHECK_FCS    = 1,
  parameter int ACCEPT_MCAST = 1,
  parameter int CNT_W        = 16
) (
  input  logic             in_rxc,
  input  logic             in_rst,
  input  logic             in_rxdv,
  input  logic [7:0]       in_rxd,
  input  logic             in_rxer,
  input  logic [47:0]      in_mac_addr,
  input  logic             in_promisc,
  output logic             out_hdr_valid,
  output logic [47:0]      out_dest_mac,
  output logic [47:0]      out_src_mac,
  output logic [15:0]      out_ether_type,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_err,
  output logic [CNT_W-1:0] out_frames_ok,
  output logic [CNT_W-1:0] out_frames_bad,
  output logic [CNT_W-1:0] out_frames_filtered
);

  localparam logic [11:0] MAX_B = 12'(MAX_FRAME);
  localparam logic [11:0] MIN_B = 12'(MIN_FRAME);

  state_t          state_q, state_d;
  logic [2:0]      pre_cnt, field_cnt, hold_cnt;
  logic [11:0]     byte_cnt;
  logic [4:0][7:0] line;
  logic            rxer_q, accept_q, giant_q;
  logic [31:0]     crc_state;
  logic [47:0]     dest_next;
  logic            fcs_bad, frame_err, dest_ok;
  logic            crc_init, crc_en, push, emit;
  logic            emit_last, term, trunc, hdr;
  logic            filt, giant;

  crc32_d8 u_crc (
    .clk   (in_rxc),
    .rst   (in_rst),
    .init  (crc_init),
    .en    (crc_en),
    .data  (in_rxd),
    .state (crc_state)
  );

  assign dest_next = {out_dest_mac[39:0], in_rxd};
  assign dest_ok = (dest_next == in_mac_addr)
                || (dest_next == BCAST_ADDR)
                || ((ACCEPT_MCAST != 0) && dest_next[40])
                || in_promisc;
  assign fcs_bad = (CHECK_FCS != 0)
                && (bitrev32(crc_state) != CRC_RESIDUE);
  assign frame_err = fcs_bad || (byte_cnt < MIN_B)
                  || rxer_q;

  // State register
  always_ff @(posedge in_rxc or posedge in_rst) begin
    if (in_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-byte control strobes
  always_comb begin
    state_d   = state_q;
    crc_init  = 1'b0;
    crc_en    = 1'b0;
    push      = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    term      = 1'b0;
    trunc     = 1'b0;
    hdr       = 1'b0;
    filt      = 1'b0;
    giant     = 1'b0;
    if (!in_rxdv) begin
      state_d = ST_IDLE;
      unique case (state_q)
        ST_DEST, ST_SRC, ST_TYPE: trunc = 1'b1;
        ST_PAYLOAD: begin
          if (hold_cnt == 3'd5) emit_last = 1'b1;
          else                  term = 1'b1;
        end
        ST_DROP: term = giant_q;
        default: ;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_rxd == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
          else                         state_d = ST_DROP;
        end
        ST_PREAMBLE: begin
          if (in_rxd == SFD_BYTE) begin
            state_d  = ST_DEST;
            crc_init = 1'b1;
          end else if (in_rxd != PREAMBLE_BYTE
                       || pre_cnt == 3'd7) begin
            state_d = ST_DROP;
          end
        end
        ST_DEST: begin
          crc_en = 1'b1;
          if (field_cnt == 3'd5) state_d = ST_SRC;
        end
        ST_SRC: begin
          crc_en = 1'b1;
          if (field_cnt == 3'd5) state_d = ST_TYPE;
        end
        ST_TYPE: begin
          crc_en = 1'b1;
          if (field_cnt == 3'd1) begin
            if (accept_q) begin
              hdr     = 1'b1;
              state_d = ST_PAYLOAD;
            end else begin
              filt    = 1'b1;
              state_d = ST_DROP;
            end
          end
        end
        ST_PAYLOAD: begin
          crc_en = 1'b1;
          if (byte_cnt >= MAX_B) begin
            giant   = 1'b1;
            state_d = ST_DROP;
          end else begin
            push = 1'b1;
            emit = (hold_cnt == 3'd5);
          end
        end
        default: ;
      endcase
    end
  end

  // Frame bookkeeping: counts, flags, holding line
  always_ff @(posedge in_rxc or posedge in_rst) begin
    if (in_rst) begin
      pre_cnt   <= '0;
      field_cnt <= '0;
      byte_cnt  <= '0;
      rxer_q    <= 1'b0;
      accept_q  <= 1'b0;
      giant_q   <= 1'b0;
      hold_cnt  <= '0;
      line      <= '0;
    end else begin
      if (state_d == ST_PREAMBLE)
        pre_cnt <= (state_q == ST_PREAMBLE)
                 ? pre_cnt + 3'd1 : 3'd1;
      if (state_d != state_q) field_cnt <= '0;
      else                    field_cnt <= field_cnt + 3'd1;
      if (crc_init) byte_cnt <= '0;
      else if (crc_en && byte_cnt != '1)
        byte_cnt <= byte_cnt + 12'd1;
      if (crc_init)              rxer_q <= 1'b0;
      else if (crc_en && in_rxer) rxer_q <= 1'b1;
      if (in_rxdv && state_q == ST_DEST
          && field_cnt == 3'd5)
        accept_q <= dest_ok;
      if (giant)                   giant_q <= 1'b1;
      else if (state_d == ST_IDLE) giant_q <= 1'b0;
      if (hdr) hold_cnt <= '0;
      else if (push) begin
        line <= {line[3:0], in_rxd};
        if (hold_cnt != 3'd5) hold_cnt <= hold_cnt + 3'd1;
      end
    end
  end

  // Header capture, first wire octet ends up in the MSBs
  always_ff @(posedge in_rxc or posedge in_rst) begin
    if (in_rst) begin
      out_dest_mac   <= '0;
      out_src_mac    <= '0;
      out_ether_type <= '0;
    end else if (in_rxdv) begin
      if (state_q == ST_DEST) out_dest_mac <= dest_next;
      if (state_q == ST_SRC)
        out_src_mac <= {out_src_mac[39:0], in_rxd};
      if (state_q == ST_TYPE)
        out_ether_type <= {out_ether_type[7:0], in_rxd};
    end
  end

  // Payload stream and header pulse
  always_ff @(posedge in_rxc or posedge in_rst) begin
    if (in_rst) begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_err       <= 1'b0;
      out_data      <= '0;
      out_hdr_valid <= 1'b0;
    end else begin
      out_valid     <= emit | emit_last | term;
      out_last      <= emit_last | term;
      out_err       <= (emit_last & frame_err) | term;
      out_hdr_valid <= hdr;
      if (emit | emit_last) out_data <= line[4];
      else if (term)        out_data <= '0;
    end
  end

  // Saturating frame statistics
  always_ff @(posedge in_rxc or posedge in_rst) begin
    if (in_rst) begin
      out_frames_ok       <= '0;
      out_frames_bad      <= '0;
      out_frames_filtered <= '0;
    end else begin
      if (emit_last && !frame_err && out_frames_ok != '1)
        out_frames_ok <= out_frames_ok + 1'b1;
      if (((emit_last && frame_err) || term || trunc)
          && out_frames_bad != '1)
        out_frames_bad <= out_frames_bad + 1'b1;
      if (filt && out_frames_filtered != '1)
        out_frames_filtered <= out_frames_filtered + 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_rx_parser.sv
// Bench for mac_rx_parser: frame table plus hand
// sequences, beats checked against a scoreboard queue.
module tb_mac_rx_parser;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BC    = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC   = 48'h02_00_00_00_00_AA;
  localparam logic [15:0] ETYPE = 16'h0800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxdv = 1'b0;
  logic rxer = 1'b0;
  logic promisc = 1'b0;
  logic [7:0] rxd = 8'h00;

  logic        hdr_v, o_valid, o_last, o_err;
  logic [47:0] o_dest, o_src;
  logic [15:0] o_type;
  logic [7:0]  o_data;
  logic [15:0] c_ok, c_bad, c_filt;

  logic        n_hdr_v, n_valid, n_last, n_err;
  logic [47:0] n_dest, n_src;
  logic [15:0] n_type;
  logic [7:0]  n_data;
  logic [15:0] n_ok, n_bad, n_filt;

  always #5 clk = ~clk;

  mac_rx_parser dut (
    .in_rxc(clk), .in_rst(rst), .in_rxdv(rxdv),
    .in_rxd(rxd), .in_rxer(rxer), .in_mac_addr(MAC),
    .in_promisc(promisc), .out_hdr_valid(hdr_v),
    .out_dest_mac(o_dest), .out_src_mac(o_src),
    .out_ether_type(o_type), .out_valid(o_valid),
    .out_data(o_data), .out_last(o_last),
    .out_err(o_err), .out_frames_ok(c_ok),
    .out_frames_bad(c_bad),
    .out_frames_filtered(c_filt)
  );

  mac_rx_parser #(.CHECK_FCS(0)) dut_nf (
    .in_rxc(clk), .in_rst(rst), .in_rxdv(rxdv),
    .in_rxd(rxd), .in_rxer(rxer), .in_mac_addr(MAC),
    .in_promisc(promisc), .out_hdr_valid(n_hdr_v),
    .out_dest_mac(n_dest), .out_src_mac(n_src),
    .out_ether_type(n_type), .out_valid(n_valid),
    .out_data(n_data), .out_last(n_last),
    .out_err(n_err), .out_frames_ok(n_ok),
    .out_frames_bad(n_bad),
    .out_frames_filtered(n_filt)
  );

  typedef struct {
    logic [47:0] dest;
    int plen;
    bit corrupt;
    int rxer_at;
    bit prom;
    int pre_len;
    int gap;
    bit hdr;
    int beats;
    bit err;
    bit term;
    int d_ok;
    int d_bad;
    int d_filt;
  } tv_t;

  tv_t tv[14];
  logic [9:0]   exp_q[$];
  logic [111:0] hdr_q[$];
  logic [7:0]   fr[$];
  int total = 0;
  int nbad = 0;
  int eok = 0, ebad = 0, efilt = 0;
  bit sb_off = 1'b0;
  bit nf_seen = 1'b0;
  bit nf_err = 1'b0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c, input logic [7:0] d);
    c = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Scoreboard: compare every emitted beat and header
  always @(negedge clk) begin
    logic [9:0]   e;
    logic [111:0] h;
    if (!sb_off && o_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        nbad++;
        $display("FAIL beat_extra: got %0h want none",
                 {o_last, o_err, o_data});
      end else begin
        e = exp_q.pop_front();
        chk("beat", {o_last, o_err, o_data}, e);
      end
    end
    if (!sb_off && hdr_v) begin
      if (hdr_q.size() == 0) begin
        total++;
        nbad++;
        $display("FAIL hdr_extra: got %0h want none",
                 o_dest);
      end else begin
        h = hdr_q.pop_front();
        chk("hdr", {o_dest, o_src, o_type}, h);
      end
    end
    if (n_valid && n_last) begin
      nf_seen = 1'b1;
      nf_err  = n_err;
    end
  end

  task automatic drive(input logic [7:0] b,
                       input logic e);
    @(negedge clk);
    rxdv = 1'b1;
    rxd  = b;
    rxer = e;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxdv = 1'b0;
      rxd  = 8'h00;
      rxer = 1'b0;
    end
  endtask

  task automatic build(input logic [47:0] dest,
                       input int plen,
                       input bit corrupt);
    logic [31:0] c;
    logic [63:0] h;
    fr.delete();
    h = {dest, 16'h0};
    for (int i = 0; i < 6; i++) fr.push_back(h[63-8*i -: 8]);
    h = {SRC, ETYPE};
    for (int i = 0; i < 8; i++) fr.push_back(h[63-8*i -: 8]);
    for (int i = 0; i < plen; i++) fr.push_back(i[7:0]);
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    if (corrupt) fr[fr.size()-4] = fr[fr.size()-4] ^ 8'h01;
  endtask

  task automatic run_vec(input tv_t t);
    logic [7:0] pb;
    bit l;
    promisc = t.prom;
    nf_seen = 1'b0;
    build(t.dest, t.plen, t.corrupt);
    if (t.hdr) hdr_q.push_back({t.dest, SRC, ETYPE});
    for (int i = 0; i < t.beats; i++) begin
      pb = i[7:0];
      l  = !t.term && (i == t.beats - 1);
      exp_q.push_back({l, l & t.err, pb});
    end
    if (t.term) exp_q.push_back(10'h300);
    eok   += t.d_ok;
    ebad  += t.d_bad;
    efilt += t.d_filt;
    for (int i = 0; i < t.pre_len; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    foreach (fr[i])
      drive(fr[i], t.rxer_at >= 0 && i == 14 + t.rxer_at);
    idle(t.gap);
    if (t.gap > 1) begin
      idle(3);
      chk("beats_left", exp_q.size(), 0);
      chk("hdr_left", hdr_q.size(), 0);
      chk("cnt_ok", c_ok, eok);
      chk("cnt_bad", c_bad, ebad);
      chk("cnt_filt", c_filt, efilt);
      if (t.corrupt) chk("nf_last_err", {nf_seen, nf_err}, 2'b10);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxdv = 1'b0;
    idle(2);
    rst = 1'b0;
    eok = 0;
    ebad = 0;
    efilt = 0;
  endtask

  initial begin
    // dest plen crc rxer prom pre gap hdr beats err term ok bad filt
    tv[0]  = '{MAC,   46,   0, -1, 0, 7, 2, 1, 46,   0, 0, 1, 0, 0};
    tv[1]  = '{MAC,   46,   1, -1, 0, 7, 2, 1, 46,   1, 0, 0, 1, 0};
    tv[2]  = '{OTHER, 46,   0, -1, 0, 7, 2, 0, 0,    0, 0, 0, 0, 1};
    tv[3]  = '{OTHER, 46,   0, -1, 1, 7, 2, 1, 46,   0, 0, 1, 0, 0};
    tv[4]  = '{BC,    46,   0, -1, 0, 7, 2, 1, 46,   0, 0, 1, 0, 0};
    tv[5]  = '{BC,    1582, 0, -1, 0, 7, 2, 1, 1499, 1, 1, 0, 1, 0};
    tv[6]  = '{MAC,   46,   0, -1, 0, 7, 1, 1, 46,   0, 0, 1, 0, 0};
    tv[7]  = '{MAC,   46,   0, -1, 0, 7, 2, 1, 46,   0, 0, 1, 0, 0};
    tv[8]  = '{MAC,   42,   0, -1, 0, 7, 2, 1, 42,   1, 0, 0, 1, 0};
    tv[9]  = '{MAC,   46,   0, 10, 0, 7, 2, 1, 46,   1, 0, 0, 1, 0};
    tv[10] = '{MAC,   46,   0, -1, 0, 8, 2, 0, 0,    0, 0, 0, 0, 0};
    tv[11] = '{MAC,   46,   0, -1, 0, 1, 2, 1, 46,   0, 0, 1, 0, 0};
    tv[12] = '{MAC,   0,    0, -1, 0, 7, 2, 1, 0,    1, 1, 0, 1, 0};
    tv[13] = '{MAC,   47,   0, -1, 0, 7, 2, 1, 47,   0, 0, 1, 0, 0};

    do_reset();
    chk("rst_valid", {hdr_v, o_valid, o_last, o_err}, 0);
    chk("rst_data", {o_data, o_dest, o_src, o_type}, 0);
    chk("rst_cnt", {c_ok, c_bad, c_filt}, 0);

    for (int i = 0; i < 14; i++) run_vec(tv[i]);

    // Broken preamble: 0x54 where 0x55 or SFD expected
    promisc = 1'b0;
    build(MAC, 46, 1'b0);
    drive(8'h55, 1'b0);
    drive(8'h55, 1'b0);
    drive(8'h54, 1'b0);
    drive(8'hD5, 1'b0);
    foreach (fr[i]) drive(fr[i], 1'b0);
    idle(4);
    chk("pre_bad_ok", c_ok, eok);
    chk("pre_bad_bad", c_bad, ebad);
    chk("pre_bad_filt", c_filt, efilt);

    // Reset in the middle of payload
    sb_off = 1'b1;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 14 + 21; i++) drive(fr[i], 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pulse", {hdr_v, o_valid, o_last, o_err}, 0);
    chk("mid_rst_data", {o_data, o_type}, 0);
    chk("mid_rst_hdr", {o_dest, o_src}, 0);
    chk("mid_rst_cnt", {c_ok, c_bad, c_filt}, 0);
    rxdv = 1'b0;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    hdr_q.delete();
    eok = 0;
    ebad = 0;
    efilt = 0;
    sb_off = 1'b0;
    idle(8);
    chk("post_rst_cnt", {c_ok, c_bad, c_filt}, 0);
    run_vec(tv[0]);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
